// File: rtl/wb_data_ram.sv
// Wishbone B4 pipelined slave data memory with byte-lane writes, a fixed-latency
// ack pipeline and an outstanding-request limit that drives o_wb_stall.
module wb_data_ram #(
  parameter int ADDR_WIDTH      = 14,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cycle,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LAST  = LATENCY - 1;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("wb_data_ram: LATENCY must be in 1..4");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY) begin : g_bad_outstanding
    $error("wb_data_ram: MAX_OUTSTANDING must be in 1..LATENCY");
  end

  logic [31:0]           mem [DEPTH];
  logic [LATENCY-1:0]    pipe_valid;
  logic [LATENCY-1:0]    pipe_read;
  logic [31:0]           pipe_data [LATENCY];
  logic [2:0]            count;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  unused_addr_bits;

  assign idx              = i_wb_addr[ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^i_wb_addr;
  assign accept           = i_wb_cycle & i_wb_stb & ~o_wb_stall;

  // Memory is deliberately left out of reset so contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (accept && i_wb_we) begin
      for (int n = 0; n < 4; n++) begin
        if (i_wb_sel[n]) mem[idx][8*n +: 8] <= i_wb_data[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_read  <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      if (!i_wb_cycle) begin
        pipe_valid <= '0;
        pipe_read  <= '0;
      end else begin
        pipe_valid[0] <= accept;
        pipe_read[0]  <= accept & ~i_wb_we;
        for (int i = 1; i < LATENCY; i++) begin
          pipe_valid[i] <= pipe_valid[i-1];
          pipe_read[i]  <= pipe_read[i-1];
        end
      end
      pipe_data[0] <= (accept && !i_wb_we) ? mem[idx] : 32'h0;
      for (int i = 1; i < LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
    end
  end

  // An accept and an ack in the same cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!i_wb_cycle) begin
      count <= '0;
    end else if (accept && !o_wb_ack) begin
      count <= count + 3'd1;
    end else if (!accept && o_wb_ack) begin
      count <= count - 3'd1;
    end
  end

  assign o_wb_stall = (count == 3'(MAX_OUTSTANDING));
  assign o_wb_ack   = pipe_valid[LAST];
  assign o_wb_data  = (pipe_valid[LAST] && pipe_read[LAST]) ? pipe_data[LAST] : 32'h0;

endmodule

// File: tb/tb_wb_data_ram.sv
// Directed bench for wb_data_ram: a default instance (LATENCY=1) and a
// LATENCY=3 / MAX_OUTSTANDING=3 instance driven from the same master signals.
module tb_wb_data_ram;

  logic        clk;
  logic        reset;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic        ack_d, stall_d;
  logic [31:0] data_d;
  logic        ack_3, stall_3;
  logic [31:0] data_3;

  int n_checks = 0;
  int n_fail   = 0;

  wb_data_ram dut_def (
    .clk(clk), .reset(reset), .i_wb_cycle(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_sel(sel), .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_ack(ack_d), .o_wb_stall(stall_d), .o_wb_data(data_d)
  );

  wb_data_ram #(.ADDR_WIDTH(14), .LATENCY(3), .MAX_OUTSTANDING(3)) dut_l3 (
    .clk(clk), .reset(reset), .i_wb_cycle(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_sel(sel), .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_ack(ack_3), .o_wb_stall(stall_3), .o_wb_data(data_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on the default instance followed by an idle cycle.
  task automatic single_req(input logic we_i, input logic [29:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic got_ack, output logic [31:0] got_data);
    cyc = 1'b1; stb = 1'b1; we = we_i; addr = a; wdata = d; sel = s;
    tick();
    got_ack  = ack_d;
    got_data = data_d;
    stb = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic idle(input int n);
    stb = 1'b0; we = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    n_checks++; if (ack_d !== 1'b0) begin n_fail++; $display("FAIL rst_ack_d: got %b exp 0", ack_d); end
    n_checks++; if (stall_d !== 1'b0) begin n_fail++; $display("FAIL rst_stall_d: got %b exp 0", stall_d); end
    n_checks++; if (data_d !== 32'h0) begin n_fail++; $display("FAIL rst_data_d: got %h exp 0", data_d); end
    n_checks++; if (ack_3 !== 1'b0 || stall_3 !== 1'b0) begin
      n_fail++; $display("FAIL rst_l3: got ack %b stall %b exp 0 0", ack_3, stall_3); end
  endtask

  task automatic test_defaults();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'h10; wdata = 32'hDEADBEEF; sel = 4'hF;
    n_checks++; if (stall_d !== 1'b0) begin n_fail++; $display("FAIL def_c0_stall: got %b exp 0", stall_d); end
    tick();
    stb = 1'b0; we = 1'b0;
    n_checks++; if (ack_d !== 1'b1 || data_d !== 32'h0) begin
      n_fail++; $display("FAIL def_wr_ack: got ack %b data %h exp 1 00000000", ack_d, data_d); end
    n_checks++; if (stall_d !== 1'b1) begin n_fail++; $display("FAIL def_c1_stall: got %b exp 1", stall_d); end
    tick();
    n_checks++; if (ack_d !== 1'b0 || stall_d !== 1'b0) begin
      n_fail++; $display("FAIL def_c2_idle: got ack %b stall %b exp 0 0", ack_d, stall_d); end
    stb = 1'b1; we = 1'b0; addr = 30'h10;
    tick();
    stb = 1'b0;
    n_checks++; if (ack_d !== 1'b1 || data_d !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL def_rd: got ack %b data %h exp 1 deadbeef", ack_d, data_d); end
    tick();
    n_checks++; if (ack_d !== 1'b0 || data_d !== 32'h0) begin
      n_fail++; $display("FAIL def_no_ack: got ack %b data %h exp 0 0", ack_d, data_d); end
    idle(4);
  endtask

  task automatic test_byte_write();
    logic a; logic [31:0] d;
    single_req(1'b1, 30'h5, 32'h11223344, 4'hF, a, d);
    single_req(1'b1, 30'h5, 32'h00AA0000, 4'b0100, a, d);
    single_req(1'b0, 30'h5, 32'h0, 4'h0, a, d);
    n_checks++; if (a !== 1'b1 || d !== 32'h11AA3344) begin
      n_fail++; $display("FAIL byte_lane2: got ack %b data %h exp 1 11aa3344", a, d); end
    single_req(1'b1, 30'h5, 32'h0000BEEF, 4'b0011, a, d);
    single_req(1'b0, 30'h5, 32'h0, 4'hF, a, d);
    n_checks++; if (a !== 1'b1 || d !== 32'h11AABEEF) begin
      n_fail++; $display("FAIL byte_lane10: got ack %b data %h exp 1 11aabeef", a, d); end
    single_req(1'b1, 30'h5, 32'hFFFFFFFF, 4'b0000, a, d);
    n_checks++; if (a !== 1'b1 || d !== 32'h0) begin
      n_fail++; $display("FAIL byte_sel0_ack: got ack %b data %h exp 1 0", a, d); end
    single_req(1'b0, 30'h5, 32'h0, 4'hF, a, d);
    n_checks++; if (d !== 32'h11AABEEF) begin
      n_fail++; $display("FAIL byte_sel0_keep: got %h exp 11aabeef", d); end
    idle(4);
  endtask

  task automatic test_back_to_back();
    logic a; logic [31:0] d;
    for (int i = 1; i <= 4; i++) single_req(1'b1, 30'(i), 32'hA0000000 | 32'(i), 4'hF, a, d);
    idle(4);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 30'h1;
    n_checks++; if (stall_3 !== 1'b0) begin n_fail++; $display("FAIL b2b_c0_stall: got %b exp 0", stall_3); end
    tick(); addr = 30'h2;
    tick(); addr = 30'h3;
    tick(); addr = 30'h4;
    n_checks++; if (stall_3 !== 1'b1 || ack_3 !== 1'b1 || data_3 !== 32'hA0000001) begin
      n_fail++; $display("FAIL b2b_c3: got stall %b ack %b data %h exp 1 1 a0000001", stall_3, ack_3, data_3); end
    tick();
    n_checks++; if (stall_3 !== 1'b0 || ack_3 !== 1'b1 || data_3 !== 32'hA0000002) begin
      n_fail++; $display("FAIL b2b_c4: got stall %b ack %b data %h exp 0 1 a0000002", stall_3, ack_3, data_3); end
    tick(); stb = 1'b0;
    n_checks++; if (ack_3 !== 1'b1 || data_3 !== 32'hA0000003) begin
      n_fail++; $display("FAIL b2b_c5: got ack %b data %h exp 1 a0000003", ack_3, data_3); end
    tick();
    n_checks++; if (ack_3 !== 1'b0) begin n_fail++; $display("FAIL b2b_c6: got ack %b exp 0", ack_3); end
    tick();
    n_checks++; if (ack_3 !== 1'b1 || data_3 !== 32'hA0000004) begin
      n_fail++; $display("FAIL b2b_c7: got ack %b data %h exp 1 a0000004", ack_3, data_3); end
    tick();
    n_checks++; if (ack_3 !== 1'b0) begin n_fail++; $display("FAIL b2b_c8: got ack %b exp 0", ack_3); end
    idle(4);
  endtask

  task automatic test_abort();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 30'h1;
    tick(); addr = 30'h2;
    tick(); cyc = 1'b0; stb = 1'b0;
    n_checks++; if (ack_3 !== 1'b0) begin n_fail++; $display("FAIL abort_c2: got ack %b exp 0", ack_3); end
    tick(); cyc = 1'b1; stb = 1'b1; addr = 30'h3;
    for (int c = 3; c <= 5; c++) begin
      n_checks++; if (ack_3 !== 1'b0 || stall_3 !== 1'b0) begin
        n_fail++; $display("FAIL abort_c%0d: got ack %b stall %b exp 0 0", c, ack_3, stall_3); end
      tick();
      addr = (c == 3) ? 30'h4 : 30'h1;
    end
    stb = 1'b0;
    n_checks++; if (ack_3 !== 1'b1 || data_3 !== 32'hA0000003 || stall_3 !== 1'b1) begin
      n_fail++; $display("FAIL abort_c6: got ack %b data %h stall %b exp 1 a0000003 1", ack_3, data_3, stall_3); end
    tick();
    n_checks++; if (ack_3 !== 1'b1 || data_3 !== 32'hA0000004) begin
      n_fail++; $display("FAIL abort_c7: got ack %b data %h exp 1 a0000004", ack_3, data_3); end
    tick();
    n_checks++; if (ack_3 !== 1'b1 || data_3 !== 32'hA0000001) begin
      n_fail++; $display("FAIL abort_c8: got ack %b data %h exp 1 a0000001", ack_3, data_3); end
    tick();
    n_checks++; if (ack_3 !== 1'b0) begin n_fail++; $display("FAIL abort_c9: got ack %b exp 0", ack_3); end
    idle(4);
  endtask

  task automatic test_async_reset();
    logic a; logic [31:0] d;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 30'h2;
    tick(); stb = 1'b0;
    n_checks++; if (ack_d !== 1'b1 || stall_d !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre: got ack %b stall %b exp 1 1", ack_d, stall_d); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (ack_d !== 1'b0 || stall_d !== 1'b0 || data_d !== 32'h0) begin
      n_fail++; $display("FAIL arst_now: got ack %b stall %b data %h exp 0 0 0", ack_d, stall_d, data_d); end
    tick();
    #2 reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++; if (ack_d !== 1'b0 || ack_3 !== 1'b0) begin
        n_fail++; $display("FAIL arst_post%0d: got ack_d %b ack_3 %b exp 0 0", c, ack_d, ack_3); end
    end
    single_req(1'b0, 30'h2, 32'h0, 4'hF, a, d);
    n_checks++; if (a !== 1'b1 || d !== 32'hA0000002) begin
      n_fail++; $display("FAIL arst_mem: got ack %b data %h exp 1 a0000002", a, d); end
    idle(4);
  endtask

  task automatic test_addr_wrap();
    logic a; logic [31:0] d;
    single_req(1'b1, 30'h0000_4003, 32'hCAFEF00D, 4'hF, a, d);
    single_req(1'b0, 30'h3, 32'h0, 4'hF, a, d);
    n_checks++; if (a !== 1'b1 || d !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL wrap_low: got ack %b data %h exp 1 cafef00d", a, d); end
    single_req(1'b0, 30'h3FFF_C003, 32'h0, 4'hF, a, d);
    n_checks++; if (d !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL wrap_high: got %h exp cafef00d", d); end
    idle(2);
  endtask

  initial begin
    reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; addr = '0; wdata = '0;
    #12;
    test_reset();
    #1 reset = 1'b0;
    tick();
    cyc = 1'b1;
    test_defaults();
    test_byte_write();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_addr_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
